// File: rtl/pb_opcode_entry.sv
// -----------------------------------------------------------------------------
// pb_opcode_entry
//
// Turns three raw, bouncy pushbuttons into a 3-bit opcode for the
// microprocessor core that sits directly downstream of this block.
//
// The operator builds an opcode by pressing buttons. Each accepted press
// toggles the matching bit of an internal accumulator. Once every button has
// been released for COMMIT_CYCLES consecutive cycles, the accumulator is
// committed to the opcode output and op_valid is raised. op_valid and opcode
// then hold until the core accepts them with op_ready. Any press that arrives
// while an opcode is still waiting to be accepted is dropped, and the sticky
// overrun flag records the loss.
//
// Parameters
//   DB_CYCLES      consecutive stable samples needed to accept a new button
//                  level (>= 2)
//   COMMIT_CYCLES  all-released idle cycles that commit an entry (>= 2)
//
// Ports
//   clk        in   1  single clock; all logic on the rising edge
//   rst        in   1  synchronous active-low reset
//   pb         in   3  raw pushbuttons, 1 = pressed
//   op_ready   in   1  core accepts the presented opcode
//   button     out  3  debounced button levels
//   press      out  3  one-cycle pulse per accepted press (none on release)
//   opcode     out  3  committed opcode
//   op_valid   out  1  opcode holds a committed entry
//   overrun    out  1  sticky: a press was ignored while an opcode was pending
//
// Build option
//   PB_SYNC_EN  when defined, pb passes through a 2-flop synchronizer before
//               the debouncer, so button follows a stable pb change after
//               2 + DB_CYCLES edges instead of DB_CYCLES edges.
// -----------------------------------------------------------------------------
module pb_opcode_entry #(
   parameter int DB_CYCLES     = 4,
   parameter int COMMIT_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] pb,
   input  logic       op_ready,
   output logic [2:0] button,
   output logic [2:0] press,
   output logic [2:0] opcode,
   output logic       op_valid,
   output logic       overrun
);

   // Counter widths leave room for the full parameter value so that the
   // terminal compare constants below are always representable.
   localparam int DB_W    = $clog2(DB_CYCLES + 1);
   localparam int TIMER_W = $clog2(COMMIT_CYCLES + 1);

   // A debounce counter sitting at DB_LAST toggles the button on its next
   // mismatching sample; the commit timer sitting at TIMER_LAST commits on its
   // next idle cycle.
   localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DB_CYCLES - 1);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(COMMIT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ENTRY = 2'd1;
   localparam logic [1:0] ST_VALID = 2'd2;

   logic [2:0]         w_sample;
   logic [2:0]         w_press;
   logic               w_anyPress;

   logic [DB_W-1:0]    r_dbCount [3];
   logic [2:0]         r_button;
   logic [2:0]         r_buttonPrev;

   logic [1:0]         r_state;
   logic [2:0]         r_acc;
   logic [TIMER_W-1:0] r_timer;
   logic [2:0]         r_opcode;
   logic               r_opValid;
   logic               r_overrun;

   logic [1:0]         w_stateNext;
   logic [2:0]         w_accNext;
   logic [TIMER_W-1:0] w_timerNext;
   logic [2:0]         w_opcodeNext;
   logic               w_opValidNext;
   logic               w_overrunNext;

`ifdef PB_SYNC_EN
   logic [2:0]         r_syncStage1;
   logic [2:0]         r_syncStage2;

   // The pushbuttons are asynchronous to clk. Two back-to-back flops give a
   // metastable first stage a full cycle to settle before the debouncer looks
   // at the level. Reset clears both stages so a button held through reset
   // is seen as a fresh transition once reset lifts.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_syncStage1 <= 3'b000;
         r_syncStage2 <= 3'b000;
      end else begin
         r_syncStage1 <= pb;
         r_syncStage2 <= r_syncStage1;
      end
   end

   assign w_sample = r_syncStage2;
`else
   // Without the synchronizer the raw pins feed the debouncer directly; the
   // integrator is responsible for pb already being in the clk domain.
   assign w_sample = pb;
`endif

   // Per-bit debouncer. Each counter measures how many consecutive samples
   // have disagreed with the current debounced level. Any agreeing sample
   // throws the run away, so a glitch shorter than DB_CYCLES samples can never
   // flip the level. When the disagreeing sample that would bring the count
   // to DB_CYCLES arrives, the level flips and the count restarts from zero;
   // the count therefore never goes past DB_CYCLES-1. The >= compare keeps it
   // from running away even if it were somehow pushed past that.
   // r_buttonPrev is the level one cycle earlier and exists only to find
   // rising edges.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            r_dbCount[i] <= '0;
         end
         r_button     <= 3'b000;
         r_buttonPrev <= 3'b000;
      end else begin
         r_buttonPrev <= r_button;
         for (int i = 0; i < 3; i++) begin
            if (w_sample[i] == r_button[i]) begin
               r_dbCount[i] <= '0;
            end else if (r_dbCount[i] >= DB_LAST) begin
               r_button[i]  <= ~r_button[i];
               r_dbCount[i] <= '0;
            end else begin
               r_dbCount[i] <= r_dbCount[i] + DB_W'(1);
            end
         end
      end
   end

   // A press is a rising edge of the debounced level, so it is high for
   // exactly the one cycle after the level is accepted. Releases (falling
   // edges) produce nothing.
   assign w_press    = r_button & ~r_buttonPrev;
   assign w_anyPress = |w_press;

   // Next-state logic for the entry FSM.
   //
   // IDLE  : nothing entered yet. The first press opens an entry.
   // ENTRY : presses toggle accumulator bits, and several simultaneous
   //         presses toggle together. The commit timer counts cycles where
   //         all buttons are released and nothing was pressed. A held button
   //         or a fresh press restarts it. Because the press test comes first,
   //         a press landing on the expiry cycle wins and the entry stays
   //         open. An accumulator of 000 is still a legal opcode and commits
   //         like any other value.
   // VALID : opcode is presented and frozen. Presses are discarded and only
   //         flagged through overrun, including a press in the very cycle the
   //         core accepts. On acceptance the accumulator is cleared so the
   //         next entry starts from zero.
   // op_ready only matters in VALID.
   always_comb begin
      w_stateNext   = r_state;
      w_accNext     = r_acc;
      w_timerNext   = r_timer;
      w_opcodeNext  = r_opcode;
      w_opValidNext = r_opValid;
      w_overrunNext = r_overrun;

      case (r_state)
         ST_IDLE: begin
            if (w_anyPress) begin
               w_accNext   = r_acc ^ w_press;
               w_timerNext = '0;
               w_stateNext = ST_ENTRY;
            end
         end

         ST_ENTRY: begin
            if (w_anyPress) begin
               w_accNext   = r_acc ^ w_press;
               w_timerNext = '0;
            end else if (r_button != 3'b000) begin
               w_timerNext = '0;
            end else if (r_timer >= TIMER_LAST) begin
               w_opcodeNext  = r_acc;
               w_opValidNext = 1'b1;
               w_timerNext   = '0;
               w_stateNext   = ST_VALID;
            end else begin
               w_timerNext = r_timer + TIMER_W'(1);
            end
         end

         ST_VALID: begin
            if (w_anyPress) begin
               w_overrunNext = 1'b1;
            end
            if (op_ready) begin
               w_opValidNext = 1'b0;
               w_accNext     = 3'b000;
               w_stateNext   = ST_IDLE;
            end
         end

         default: begin
            w_stateNext   = ST_IDLE;
            w_accNext     = 3'b000;
            w_timerNext   = '0;
            w_opValidNext = 1'b0;
         end
      endcase
   end

   // Entry FSM registers. Reset throws away any half-built entry or unaccepted
   // opcode, so nothing appears on op_valid after reset lifts unless a new
   // entry is made.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_acc     <= 3'b000;
         r_timer   <= '0;
         r_opcode  <= 3'b000;
         r_opValid <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_stateNext;
         r_acc     <= w_accNext;
         r_timer   <= w_timerNext;
         r_opcode  <= w_opcodeNext;
         r_opValid <= w_opValidNext;
         r_overrun <= w_overrunNext;
      end
   end

   assign button   = r_button;
   assign press    = w_press;
   assign opcode   = r_opcode;
   assign op_valid = r_opValid;
   assign overrun  = r_overrun;

endmodule

// File: tb/tb_pb_opcode_entry.sv
// -----------------------------------------------------------------------------
// tb_pb_opcode_entry
//
// Self-checking bench for pb_opcode_entry. A behavioural reference model
// follows every clock edge and all DUT outputs are compared against it each
// cycle. A table of directed rows and some hand-written sequences cover the
// reset, bounce, glitch-length, commit-priority and overrun corners, and a
// randomized phase follows.
// Works with or without PB_SYNC_EN defined.
// -----------------------------------------------------------------------------
module tb_pb_opcode_entry;

   localparam int DB_CYCLES     = 4;
   localparam int COMMIT_CYCLES = 16;
`ifdef PB_SYNC_EN
   localparam int SYNC_DEPTH = 2;
`else
   localparam int SYNC_DEPTH = 0;
`endif
   // Edges from a stable pb change to the matching button change.
   localparam int ACCEPT_LAT = SYNC_DEPTH + DB_CYCLES;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [2:0] pb = 3'b000;
   logic       op_ready = 1'b0;
   logic [2:0] button;
   logic [2:0] press;
   logic [2:0] opcode;
   logic       op_valid;
   logic       overrun;

   int vectors = 0;
   int miscompares = 0;

   // Reference model state
   logic [2:0] mButton = 3'b000;
   logic [2:0] mPrev = 3'b000;
   logic [2:0] mAcc = 3'b000;
   logic [2:0] mOpcode = 3'b000;
   logic       mValid = 1'b0;
   logic       mOverrun = 1'b0;
   bit         mEntryOpen = 1'b0;
   int         mQuiet = 0;
   logic [2:0] pbDelay[$];
   logic [2:0] window[$];

   typedef struct {
      logic [2:0] pb;
      logic       opReady;
      int         cycles;
      logic [2:0] expOpcode;
      logic       expValid;
      logic       expOverrun;
   } vec_t;

   vec_t vecs[$];

   pb_opcode_entry #(
      .DB_CYCLES(DB_CYCLES),
      .COMMIT_CYCLES(COMMIT_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pb(pb),
      .op_ready(op_ready),
      .button(button),
      .press(press),
      .opcode(opcode),
      .op_valid(op_valid),
      .overrun(overrun)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Watchdog so the run can never hang.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model of one rising edge, using the inputs present at that edge.
   // Debounce: a button level flips once its last DB_CYCLES samples all
   // disagree with it. Commit: an open entry commits once the buttons have been
   // all-released for COMMIT_CYCLES consecutive press-free cycles.
   function automatic void modelEdge();
      logic [2:0] sample;
      logic [2:0] pressNow;
      logic [2:0] nextButton;
      bit         allDiffer;
      if (rst === 1'b0) begin
         mButton = 3'b000;
         mPrev = 3'b000;
         mAcc = 3'b000;
         mOpcode = 3'b000;
         mValid = 1'b0;
         mOverrun = 1'b0;
         mEntryOpen = 1'b0;
         mQuiet = 0;
         pbDelay.delete();
         for (int k = 0; k < SYNC_DEPTH; k++) pbDelay.push_back(3'b000);
         window.delete();
         return;
      end
      pbDelay.push_back(pb);
      sample = pbDelay.pop_front();
      window.push_back(sample);
      if (window.size() > DB_CYCLES) void'(window.pop_front());

      pressNow = mButton & ~mPrev;
      nextButton = mButton;
      if (window.size() == DB_CYCLES) begin
         for (int b = 0; b < 3; b++) begin
            allDiffer = 1'b1;
            foreach (window[j]) if (window[j][b] == mButton[b]) allDiffer = 1'b0;
            if (allDiffer) nextButton[b] = ~mButton[b];
         end
      end

      if (mValid) begin
         if (pressNow != 3'b000) mOverrun = 1'b1;
         if (op_ready) begin
            mValid = 1'b0;
            mAcc = 3'b000;
            mEntryOpen = 1'b0;
         end
      end else if (pressNow != 3'b000) begin
         mAcc = mAcc ^ pressNow;
         mEntryOpen = 1'b1;
         mQuiet = 0;
      end else if (mEntryOpen) begin
         if (mButton != 3'b000) begin
            mQuiet = 0;
         end else begin
            mQuiet = mQuiet + 1;
            if (mQuiet == COMMIT_CYCLES) begin
               mOpcode = mAcc;
               mValid = 1'b1;
               mEntryOpen = 1'b0;
               mQuiet = 0;
            end
         end
      end

      mPrev = mButton;
      mButton = nextButton;
   endfunction

   function automatic logic [31:0] dutVec();
      return {21'd0, button, press, opcode, op_valid, overrun};
   endfunction

   function automatic logic [31:0] modelVec();
      return {21'd0, mButton, mButton & ~mPrev, mOpcode, mValid, mOverrun};
   endfunction

   // One comparison: counts it, and reports it if it does not match.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Advance one edge, step the model and compare all outputs 1 ns later.
   task automatic tick();
      @(posedge clk);
      modelEdge();
      #1;
      checkOutput("model_cycle", dutVec(), modelVec());
   endtask

   task automatic applyStimulus(input logic [2:0] pbVal, input logic readyVal, input int n);
      pb = pbVal;
      op_ready = readyVal;
      repeat (n) tick();
   endtask

   task automatic doReset(input int n);
      rst = 1'b0;
      repeat (n) tick();
      rst = 1'b1;
   endtask

   initial begin
      int pulses;
      bit sawButton;
      int ticks;
      int kind;
      int hold;

      // Directed table: two-button entry, net-zero entry, overrun then
      // a fresh entry starting from a cleared accumulator.
      vecs.push_back('{3'b001, 1'b0,  8, 3'b000, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 1'b0,  8, 3'b000, 1'b0, 1'b0});
      vecs.push_back('{3'b010, 1'b0,  8, 3'b000, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 1'b0, 12, 3'b000, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 1'b0, 12, 3'b011, 1'b1, 1'b0});
      vecs.push_back('{3'b000, 1'b0,  5, 3'b011, 1'b1, 1'b0});
      vecs.push_back('{3'b000, 1'b1,  1, 3'b011, 1'b0, 1'b0});
      vecs.push_back('{3'b100, 1'b0,  8, 3'b011, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 1'b0,  8, 3'b011, 1'b0, 1'b0});
      vecs.push_back('{3'b100, 1'b0,  8, 3'b011, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 1'b0, 30, 3'b000, 1'b1, 1'b0});
      vecs.push_back('{3'b000, 1'b1,  1, 3'b000, 1'b0, 1'b0});
      vecs.push_back('{3'b001, 1'b0,  8, 3'b000, 1'b0, 1'b0});
      vecs.push_back('{3'b000, 1'b0, 30, 3'b001, 1'b1, 1'b0});
      vecs.push_back('{3'b001, 1'b0,  8, 3'b001, 1'b1, 1'b1});
      vecs.push_back('{3'b000, 1'b0,  8, 3'b001, 1'b1, 1'b1});
      vecs.push_back('{3'b000, 1'b1,  1, 3'b001, 1'b0, 1'b1});
      vecs.push_back('{3'b010, 1'b0,  8, 3'b001, 1'b0, 1'b1});
      vecs.push_back('{3'b000, 1'b0, 30, 3'b010, 1'b1, 1'b1});
      vecs.push_back('{3'b000, 1'b1,  1, 3'b010, 1'b0, 1'b1});

      $display("[TB] start, accept latency %0d edges", ACCEPT_LAT);

      // Reset with all buttons held, then the held buttons read as new presses.
      pb = 3'b111;
      doReset(3);
      checkOutput("reset_outputs", dutVec(), 32'd0);
      for (int e = 1; e < ACCEPT_LAT; e++) begin
         tick();
         checkOutput("button_before_accept", {29'd0, button}, 32'd0);
      end
      tick();
      checkOutput("button_accept_edge", {29'd0, button}, 32'd7);
      checkOutput("press_pulse", {29'd0, press}, 32'd7);
      tick();
      checkOutput("press_one_cycle", {29'd0, press}, 32'd0);
      applyStimulus(3'b000, 1'b0, 30);
      checkOutput("commit_111_valid", {31'd0, op_valid}, 32'd1);
      checkOutput("commit_111_opcode", {29'd0, opcode}, 32'd7);
      applyStimulus(3'b000, 1'b1, 1);
      checkOutput("handshake_clears_valid", {31'd0, op_valid}, 32'd0);
      op_ready = 1'b0;
      doReset(2);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].pb, vecs[i].opReady, vecs[i].cycles);
         checkOutput($sformatf("row%0d_opcode", i), {29'd0, opcode}, {29'd0, vecs[i].expOpcode});
         checkOutput($sformatf("row%0d_valid", i), {31'd0, op_valid}, {31'd0, vecs[i].expValid});
         checkOutput($sformatf("row%0d_overrun", i), {31'd0, overrun}, {31'd0, vecs[i].expOverrun});
      end

      // Press landing in the cycle where the commit timer would expire.
      applyStimulus(3'b001, 1'b0, 8);
      applyStimulus(3'b000, 1'b0, 15);
      applyStimulus(3'b010, 1'b0, ACCEPT_LAT);
      checkOutput("press_at_expiry_align", {29'd0, press}, 32'd2);
      applyStimulus(3'b010, 1'b0, 1);
      checkOutput("no_commit_on_press", {31'd0, op_valid}, 32'd0);
      applyStimulus(3'b010, 1'b0, 4);
      applyStimulus(3'b000, 1'b0, 12);
      checkOutput("timer_restarted", {31'd0, op_valid}, 32'd0);
      applyStimulus(3'b000, 1'b0, 12);
      checkOutput("late_commit_valid", {31'd0, op_valid}, 32'd1);
      checkOutput("late_commit_opcode", {29'd0, opcode}, 32'd3);
      applyStimulus(3'b000, 1'b1, 1);
      op_ready = 1'b0;

      // Bouncing pb[0]: one-cycle pulses, then stable high.
      pulses = 0;
      sawButton = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pb = (i % 2 == 0) ? 3'b001 : 3'b000;
         tick();
         if (press[0]) pulses++;
         if (button[0]) sawButton = 1'b1;
      end
      checkOutput("bounce_no_button", {31'd0, sawButton}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         pb = 3'b001;
         tick();
         if (press[0]) pulses++;
      end
      checkOutput("bounce_press_count", pulses, 32'd1);
      applyStimulus(3'b000, 1'b0, 30);
      checkOutput("bounce_commit_opcode", {29'd0, opcode}, 32'd1);
      applyStimulus(3'b000, 1'b1, 1);
      op_ready = 1'b0;

      // Glitch one sample short of the debounce length is ignored.
      sawButton = 1'b0;
      pb = 3'b001;
      for (int i = 0; i < DB_CYCLES - 1; i++) begin
         tick();
         if (button[0]) sawButton = 1'b1;
      end
      pb = 3'b000;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (button[0]) sawButton = 1'b1;
      end
      checkOutput("glitch_short_ignored", {31'd0, sawButton}, 32'd0);
      // Exactly DB_CYCLES samples is accepted as one press.
      pulses = 0;
      pb = 3'b001;
      for (int i = 0; i < DB_CYCLES; i++) begin
         tick();
         if (press[0]) pulses++;
      end
      pb = 3'b000;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (press[0]) pulses++;
      end
      checkOutput("glitch_exact_accepted", pulses, 32'd1);
      applyStimulus(3'b000, 1'b0, 30);
      applyStimulus(3'b000, 1'b1, 1);
      op_ready = 1'b0;

      // Reset mid-entry discards the entry.
      applyStimulus(3'b100, 1'b0, 8);
      applyStimulus(3'b000, 1'b0, 5);
      doReset(2);
      applyStimulus(3'b000, 1'b0, 30);
      checkOutput("reset_mid_entry", {31'd0, op_valid}, 32'd0);

      // Reset while an opcode is waiting discards it.
      applyStimulus(3'b010, 1'b0, 8);
      applyStimulus(3'b000, 1'b0, 30);
      checkOutput("valid_before_reset", {31'd0, op_valid}, 32'd1);
      doReset(1);
      checkOutput("reset_in_valid", {31'd0, op_valid}, 32'd0);
      applyStimulus(3'b000, 1'b0, 30);
      checkOutput("no_valid_after_reset", {31'd0, op_valid}, 32'd0);

      // Randomized traffic against the model, with occasional resets.
      ticks = 0;
      while (ticks < 4000) begin
         kind = $urandom_range(0, 9);
         if (kind < 4) begin
            pb = 3'($urandom_range(0, 7));
            hold = $urandom_range(1, 4);
         end else if (kind < 7) begin
            pb = 3'($urandom_range(0, 7));
            hold = $urandom_range(4, 10);
         end else begin
            pb = 3'b000;
            hold = $urandom_range(10, 25);
         end
         for (int h = 0; h < hold; h++) begin
            op_ready = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            tick();
            ticks++;
         end
      end
      rst = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pb_opcode_entry.md
PB_OPCODE_ENTRY -- requirements
Module: pb_opcode_entry

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DB_CYCLES, 4, consecutive stable samples needed to accept a new button level (>=2).
- COMMIT_CYCLES, 16, all-released idle cycles that commit an entry (>=2).
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, single clock; all logic on the rising edge.
- rst, input, 1, synchronous active-low reset.
- pb, input, 3, raw bouncy pushbuttons, 1 = pressed.
- op_ready, input, 1, microprocessor accepts opcode.
- button, output, 3, debounced button levels.
- press, output, 3, one-cycle press pulses.
- opcode, output, 3, committed opcode.
- op_valid, output, 1, opcode holds a committed entry.
- overrun, output, 1, sticky flag: a press was ignored.
REQ-003 The block SHALL sit directly upstream of the microprocessor core and drive its opcode/button inputs.

Function
REQ-004 Each pb bit SHALL be debounced independently: a per-bit counter increments while the sampled level differs from button[i] and clears to 0 when they match.
REQ-005 button[i] SHALL toggle on the edge where its counter would reach DB_CYCLES, and the counter SHALL clear on that edge.
REQ-006 A glitch shorter than DB_CYCLES sampled cycles SHALL never change button[i].
REQ-007 press[i] SHALL equal button[i] AND NOT button[i] of the previous cycle, giving exactly one high cycle per accepted press; release SHALL produce no pulse.
REQ-008 The FSM SHALL have states IDLE, ENTRY and VALID, and SHALL hold an internal 3-bit accumulator acc.
REQ-009 In IDLE, any press SHALL XOR press into acc, clear the commit timer and move to ENTRY.
REQ-010 In ENTRY, a press SHALL XOR press into acc and clear the timer.
REQ-011 In ENTRY, the timer SHALL increment each cycle with button==000 and no press, and SHALL clear whenever any button is held.
REQ-012 When the timer reaches COMMIT_CYCLES-1 and increments, the FSM SHALL load opcode<=acc, set op_valid=1 and enter VALID.
REQ-013 A press in the same cycle as timer expiry SHALL take priority: toggle acc, clear the timer, stay in ENTRY.
REQ-014 Multiple bits pressed in one cycle SHALL all toggle together.
REQ-015 A net-zero entry (acc==000) SHALL still commit opcode 000.
REQ-016 In VALID, op_valid and opcode SHALL hold until op_valid&&op_ready; on that edge op_valid SHALL go 0, acc SHALL clear and the FSM SHALL return to IDLE.
REQ-017 A press during VALID, including the handshake cycle, SHALL NOT affect acc and SHALL set overrun=1.
REQ-018 op_ready SHALL be ignored outside VALID.
REQ-019 The timer SHALL be sized for COMMIT_CYCLES and SHALL NOT wrap; debounce counters SHALL saturate at DB_CYCLES.

Reset
REQ-020 When rst==0 at a clock edge, all state SHALL clear: button=000, press=000, opcode=000, op_valid=0, overrun=0, acc=000, counters=0, FSM=IDLE, synchronizer flops=000.
REQ-021 Reset mid-entry or in VALID SHALL discard the pending entry, with no op_valid pulse after release.
REQ-022 A pb held high through reset release SHALL be debounced as a new press.

Configuration
REQ-023 With macro PB_SYNC_EN defined, pb SHALL pass through a 2-flop synchronizer before debouncing, so button changes 2+DB_CYCLES edges after a stable pb change.
REQ-024 Without PB_SYNC_EN, pb SHALL feed the debouncer directly, so button changes DB_CYCLES edges after a stable pb change; all other behaviour is identical.

Verification (defaults, PB_SYNC_EN defined)
REQ-025 Reset held 3 cycles with pb=111 -> all outputs 0; after release, button=111 on the 6th edge and press=111 for one cycle.
REQ-026 pb[0] bouncing 1-cycle pulses for 10 cycles, then stable high for 8 cycles -> exactly one press[0] pulse; no button change during bouncing.
REQ-027 Press/release pb[0], then pb[1], then wait 16 idle cycles with op_ready=0 -> opcode=011, op_valid=1 held; op_ready=1 for one cycle -> op_valid=0 next cycle.
REQ-028 Press pb[2] twice, then idle -> commits opcode=000 with op_valid=1.
REQ-029 Press pb[1] in the cycle where the timer would expire -> no commit; the timer restarts; a later commit gives opcode=acc^010.
REQ-030 Press pb[0] while op_valid=1 -> overrun=1, opcode unchanged, next entry starts from acc=000.
